vga_sync: RTL and testbench
===========================

# vga_sync

Raster timing generator for the Pong display path, driven from the 25 MHz pixel clock. Produces the current pixel coordinate, the visible-area flag, active-low VGA sync pulses and per-line/per-frame strobes. Every object renderer (ball, paddles, score) consumes `x`, `y`, `vga_on` and the frame strobe from this block, and the top level muxes their `rgb` outputs onto the connector alongside `hsync` and `vsync`.

## Interface
- `H_VIS`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_VIS`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `FRAME_LINE`, 481, line on which `frame_tick` fires (at `x == 0`)

Ports:
- `clk25M` in 1: pixel clock, all logic on rising edge
- `reset` in 1: synchronous, active-high
- `x` out 10: current column, 0 .. H_TOTAL-1
- `y` out 10: current line, 0 .. V_TOTAL-1
- `vga_on` out 1: high when `x < H_VIS` and `y < V_VIS`
- `hsync` out 1: active-low horizontal sync
- `vsync` out 1: active-low vertical sync
- `line_tick` out 1: one-cycle pulse when `x == H_TOTAL-1`
- `frame_tick` out 1: one-cycle pulse when `x == 0` and `y == FRAME_LINE`
- `frame_cnt` out 8: frames completed (only with `VGA_FRAME_CNT_EN`)

## Operation
- H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_VIS+V_FP+V_SYNC+V_BP (525).
- Horizontal counter increments every cycle; at H_TOTAL-1 it wraps to 0 and the vertical counter advances.
- Vertical counter wraps V_TOTAL-1 → 0 only in the cycle the horizontal counter wraps.
- `hsync` low for `H_VIS+H_FP <= x < H_VIS+H_FP+H_SYNC` (656..751), high otherwise.
- `vsync` low for `V_VIS+V_FP <= y < V_VIS+V_FP+V_SYNC` (490..491), high for the whole of those lines otherwise.
- All outputs are flops. Decode uses the next-count values, so every output in a given cycle describes the same (`x`,`y`) pair; there is no skew between coordinate and flags.
- `frame_tick` is the single game-update strobe: exactly one cycle per frame, outside the visible area, so object state updates never tear the picture.
- Counter widths: 10 bits each; parameters must keep H_TOTAL, V_TOTAL ≤ 1024 (no saturation logic; overflow is a configuration error).

## Timing
- Reset values (cycle after `reset` sampled high): `x=0`, `y=0`, `vga_on=1`, `hsync=1`, `vsync=1`, `line_tick=0`, `frame_tick=0`, `frame_cnt=0`.
- First cycle after `reset` deasserts: `x=1`, `y=0`.
- Reset mid-frame: the next edge forces the reset values regardless of position. No partial sync pulse is stretched; `hsync`/`vsync` return high immediately.
- Line wrap: the cycle with `x=799` has `line_tick=1`. The next cycle has `x=0`, `y+1`.
- Frame wrap: `x=799,y=524` → `x=0,y=0`. Both `line_tick` is high in the 799 cycle.
- Line period 800 cycles; frame period 420 000 cycles; `frame_tick` spacing exactly 420 000 cycles.

## Configuration
- `VGA_FRAME_CNT_EN` defined: `frame_cnt` port present. It increments by 1 on the frame wrap edge (`x=799,y=524` → `0,0`), wraps 255 → 0, and clears on reset.
- Not defined: the port and register are absent. All other behaviour is identical.

## Test plan
- Reset held 3 cycles, released → `x=0,y=0,vga_on=1,hsync=1,vsync=1`; next cycle `x=1`.
- Run 800 cycles from reset → `line_tick` high only at `x=799`; next cycle `x=0,y=1`; `hsync` low exactly for 96 cycles, x=656..751.
- Run a full frame → `vga_on` high for exactly 307 200 cycles; `vsync` low for exactly 1600 cycles, y=490..491; `x=799,y=524` wraps to `0,0`.
- Count `frame_tick` over 3 frames → exactly 3 pulses, each at `x=0,y=481`, spaced 420 000 cycles.
- Assert `reset` at `x=700,y=490` (inside both sync pulses) → next cycle `hsync=1,vsync=1,x=0,y=0`.
- With `VGA_FRAME_CNT_EN`: run 257 frames → `frame_cnt` reads 1 after the 257th wrap (255 → 0 → 1); reset clears it to 0.

Source files
------------

// File: rtl/vga_sync.sv
// rtl/vga_sync.sv - VGA raster timing generator (coordinates, visible flag, syncs, line/frame strobes)
// Optional frame counter port enabled by defining VGA_FRAME_CNT_EN.
module vga_sync #(
    parameter int H_VIS      = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_VIS      = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int FRAME_LINE = 481
) (
    input  logic       clk25M,
    input  logic       reset,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       vga_on,
    output logic       hsync,
    output logic       vsync,
    output logic       line_tick,
`ifdef VGA_FRAME_CNT_EN
    output logic       frame_tick,
    output logic [7:0] frame_cnt
`else
    output logic       frame_tick
`endif
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_END  = 10'(H_VIS);
    localparam logic [9:0] V_VIS_END  = 10'(V_VIS);
    localparam logic [9:0] HS_START   = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END     = 10'(V_VIS + V_FP + V_SYNC);
    localparam logic [9:0] FRAME_Y    = 10'(FRAME_LINE);

    logic [9:0] x_next;
    logic [9:0] y_next;

    always_comb begin
        x_next = x + 10'd1;
        y_next = y;
        if (x == H_LAST) begin
            x_next = 10'd0;
            y_next = (y == V_LAST) ? 10'd0 : y + 10'd1;
        end
    end

    // Flags are decoded from the next coordinate so they land in the same cycle as it.
    always_ff @(posedge clk25M) begin
        if (reset) begin
            x          <= 10'd0;
            y          <= 10'd0;
            vga_on     <= 1'b1;
            hsync      <= 1'b1;
            vsync      <= 1'b1;
            line_tick  <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            x          <= x_next;
            y          <= y_next;
            vga_on     <= (x_next < H_VIS_END) && (y_next < V_VIS_END);
            hsync      <= !((x_next >= HS_START) && (x_next < HS_END));
            vsync      <= !((y_next >= VS_START) && (y_next < VS_END));
            line_tick  <= (x_next == H_LAST);
            frame_tick <= (x_next == 10'd0) && (y_next == FRAME_Y);
        end
    end

`ifdef VGA_FRAME_CNT_EN
    always_ff @(posedge clk25M) begin
        if (reset) begin
            frame_cnt <= 8'd0;
        end else if ((x == H_LAST) && (y == V_LAST)) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_sync.sv
// tb/tb_vga_sync.sv - directed self-checking bench for vga_sync (full-size line plus reduced-geometry frames)
module tb_vga_sync;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] x, y, xf, yf;
    logic       vga_on, hsync, vsync, line_tick, frame_tick;
    logic       vga_on_f, hsync_f, vsync_f, line_tick_f, frame_tick_f;
`ifdef VGA_FRAME_CNT_EN
    logic [7:0] frame_cnt, frame_cnt_f;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    int ex, ey, p, prev_ft, found;
    int hs_low, hs_first, hs_last, lt_cnt, lt_x, xerr;
    int m_xy, m_on, m_hs, m_vs, m_lt, m_ft, on_cnt, vs_low, ft_cnt, sp_err;
    logic e_on, e_hs, e_vs, e_lt, e_ft;

    always #20 clk = ~clk;

    // Reduced geometry: H_TOTAL=20 (hsync x=12..15), V_TOTAL=15 (vsync y=10..11), frame = 300 cycles.
    vga_sync #(
        .H_VIS(10), .H_FP(2), .H_SYNC(4), .H_BP(4),
        .V_VIS(8), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .FRAME_LINE(9)
    ) dut (
        .clk25M(clk), .reset(reset), .x(x), .y(y), .vga_on(vga_on),
        .hsync(hsync), .vsync(vsync), .line_tick(line_tick),
`ifdef VGA_FRAME_CNT_EN
        .frame_tick(frame_tick), .frame_cnt(frame_cnt)
`else
        .frame_tick(frame_tick)
`endif
    );

    vga_sync dut_full (
        .clk25M(clk), .reset(reset), .x(xf), .y(yf), .vga_on(vga_on_f),
        .hsync(hsync_f), .vsync(vsync_f), .line_tick(line_tick_f),
`ifdef VGA_FRAME_CNT_EN
        .frame_tick(frame_tick_f), .frame_cnt(frame_cnt_f)
`else
        .frame_tick(frame_tick_f)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) step();
        check("rst_x", 32'(x), 0);
        check("rst_y", 32'(y), 0);
        check("rst_vga_on", 32'(vga_on), 1);
        check("rst_hsync", 32'(hsync), 1);
        check("rst_vsync", 32'(vsync), 1);
        check("rst_line_tick", 32'(line_tick), 0);
        check("rst_frame_tick", 32'(frame_tick), 0);
        check("rst_full_hsync", 32'(hsync_f), 1);
        check("rst_full_vsync", 32'(vsync_f), 1);
        reset = 1'b0;
        step();
        check("first_x", 32'(x), 1);
        check("first_y", 32'(y), 0);
        check("first_full_x", 32'(xf), 1);

        // One full-size line
        hs_low = 0; hs_first = -1; hs_last = -1; lt_cnt = 0; lt_x = -1; xerr = 0;
        for (int i = 1; i < 800; i++) begin
            if (xf !== 10'(i) || yf !== 10'd0) xerr++;
            if (hsync_f === 1'b0) begin
                hs_low++;
                if (hs_first < 0) hs_first = int'(xf);
                hs_last = int'(xf);
            end
            if (line_tick_f === 1'b1) begin
                lt_cnt++;
                lt_x = int'(xf);
            end
            step();
        end
        check("line_coord_errors", 32'(xerr), 0);
        check("hsync_low_cycles", 32'(hs_low), 96);
        check("hsync_first_x", 32'(hs_first), 656);
        check("hsync_last_x", 32'(hs_last), 751);
        check("line_tick_count", 32'(lt_cnt), 1);
        check("line_tick_x", 32'(lt_x), 799);
        check("line_wrap_x", 32'(xf), 0);
        check("line_wrap_y", 32'(yf), 1);
        check("line_wrap_tick_low", 32'(line_tick_f), 0);

        // Three reduced frames against a geometric reference
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        step();
        m_xy = 0; m_on = 0; m_hs = 0; m_vs = 0; m_lt = 0; m_ft = 0;
        on_cnt = 0; vs_low = 0; ft_cnt = 0; sp_err = 0; prev_ft = -1;
        for (p = 1; p <= 900; p++) begin
            ex = p % 20;
            ey = (p / 20) % 15;
            e_on = (ex < 10) && (ey < 8);
            e_hs = !((ex >= 12) && (ex < 16));
            e_vs = !((ey >= 10) && (ey < 12));
            e_lt = (ex == 19);
            e_ft = (ex == 0) && (ey == 9);
            if (x !== 10'(ex) || y !== 10'(ey)) m_xy++;
            if (vga_on !== e_on) m_on++;
            if (hsync !== e_hs) m_hs++;
            if (vsync !== e_vs) m_vs++;
            if (line_tick !== e_lt) m_lt++;
            if (frame_tick !== e_ft) m_ft++;
            if (vga_on === 1'b1) on_cnt++;
            if (vsync === 1'b0) vs_low++;
            if (frame_tick === 1'b1) begin
                ft_cnt++;
                if (prev_ft >= 0 && p - prev_ft != 300) sp_err++;
                prev_ft = p;
            end
            if (p == 299) begin
                check("pre_wrap_x", 32'(x), 19);
                check("pre_wrap_y", 32'(y), 14);
                check("pre_wrap_line_tick", 32'(line_tick), 1);
            end
            if (p == 300) begin
                check("frame_wrap_x", 32'(x), 0);
                check("frame_wrap_y", 32'(y), 0);
            end
            step();
        end
        check("frame_xy_mismatches", 32'(m_xy), 0);
        check("frame_vga_on_mismatches", 32'(m_on), 0);
        check("frame_hsync_mismatches", 32'(m_hs), 0);
        check("frame_vsync_mismatches", 32'(m_vs), 0);
        check("frame_line_tick_mismatches", 32'(m_lt), 0);
        check("frame_tick_mismatches", 32'(m_ft), 0);
        check("vga_on_cycles", 32'(on_cnt), 240);
        check("vsync_low_cycles", 32'(vs_low), 120);
        check("frame_tick_count", 32'(ft_cnt), 3);
        check("frame_tick_spacing_errors", 32'(sp_err), 0);

        // Reset while inside both sync pulses
        found = 0;
        for (int i = 0; i < 400 && found == 0; i++) begin
            if (x === 10'd14 && y === 10'd10) found = 1;
            else step();
        end
        check("mid_reset_position_found", 32'(found), 1);
        check("mid_hsync_low", 32'(hsync), 0);
        check("mid_vsync_low", 32'(vsync), 0);
        reset = 1'b1;
        step();
        check("mid_rst_hsync", 32'(hsync), 1);
        check("mid_rst_vsync", 32'(vsync), 1);
        check("mid_rst_x", 32'(x), 0);
        check("mid_rst_y", 32'(y), 0);
        check("mid_rst_vga_on", 32'(vga_on), 1);
        reset = 1'b0;
        step();
        check("mid_release_x", 32'(x), 1);

`ifdef VGA_FRAME_CNT_EN
        check("frame_cnt_after_reset", 32'(frame_cnt), 0);
        repeat (76799) step();
        check("frame_cnt_256_wraps", 32'(frame_cnt), 0);
        repeat (300) step();
        check("frame_cnt_257_wraps", 32'(frame_cnt), 1);
        check("frame_cnt_wrap_x", 32'(x), 0);
        check("frame_cnt_wrap_y", 32'(y), 0);
        reset = 1'b1;
        step();
        check("frame_cnt_reset", 32'(frame_cnt), 0);
        reset = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
